keypad_scanner: RTL

//  Input-side counterpart of the multiplexed 7-segment driver: scans a 4x4 matrix keypad
//  by driving one active-low row at a time and reading four active-low column lines.

---
 rtl/keypad_scanner.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces the whole 16-key matrix frame by frame, and hands out one key
// code per clean single-key press through a valid/ready holding register.
module keypad_scanner #(
  parameter int CLK_FREQ        = 1_000,
  parameter int SCAN_RATE       = 60,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [3:0] row_pins_o,
  input  logic [3:0] col_pins_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic       pressed_o,
  output logic       overflow_o
);

  // Cycles spent on each row; must leave room for the 2-flop column sync.
  localparam int SCAN_PERIOD = CLK_FREQ / (SCAN_RATE * 4);
  localparam int DIV_W       = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int CNT_W       = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0]       col_meta_q, col_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_pins_q, row_pins_d;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      deb_q, deb_d;
  logic             pressed_q;
  logic             evt_q, evt_d;
  logic [3:0]       evt_idx_q, evt_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overflow_q, overflow_d;

  logic             tick, frame_end, accept;
  logic [3:0]       col_hit;

  // Two-flop synchronizer for the asynchronous column inputs (idle high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every register uses <= so all flops sample pre-edge values together.
    if (!rst_ni) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_pins_i;
      col_sync_q <= col_meta_q;
    end
  end

  // Row divider, row walk, frame snapshot and frame-level debounce.
  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches.
    tick       = en_i && (div_q == DIV_LAST);
    frame_end  = tick && (row_q == 2'd3);
    div_d      = div_q + 1'b1;
    row_d      = row_q;
    snap_d     = snap_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    row_pins_d = 4'b1111 ^ (4'b1000 >> row_q);
    // Column c is wired to col_pins[3-c]; flip to key-index order.
    for (int c = 0; c < 4; c++) col_hit[c] = ~col_sync_q[3-c];

    if (!en_i) begin
      div_d      = '0;
      row_d      = 2'd0;
      snap_d     = '0;
      cand_d     = '0;
      cnt_d      = '0;
      deb_d      = '0;
      row_pins_d = 4'b1111;
    end else if (tick) begin
      div_d                      = '0;
      row_d                      = row_q + 2'd1;
      snap_d[{row_q, 2'b00} +: 4] = col_hit;
      if (frame_end) begin
        if (snap_d == cand_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          cand_d = snap_d;
          cnt_d  = CNT_W'(1);
        end
        if (cnt_d == CNT_MAX) deb_d = cand_d;
      end
    end
  end

  // A press event is a step from no keys held to exactly one key held.
  always_comb begin
    evt_d     = en_i && (deb_q == 16'h0000) && $onehot(deb_d);
    evt_idx_d = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (deb_d[i]) evt_idx_d = 4'(i);
    end
  end

  // Holding register: load on event, clear on handshake, flag drops.
  always_comb begin
    accept      = key_valid_q & key_ready_i;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overflow_d  = 1'b0;
    if (evt_q) begin
      if (!key_valid_q || accept) begin
        key_code_d  = evt_idx_q;
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (accept) begin
      key_valid_d = 1'b0;
    end
  end

  // State register for scan, debounce, event and holding logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q       <= '0;
      row_q       <= 2'd0;
      row_pins_q  <= 4'b1111;
      snap_q      <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      deb_q       <= '0;
      pressed_q   <= 1'b0;
      evt_q       <= 1'b0;
      evt_idx_q   <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_q       <= row_d;
      row_pins_q  <= row_pins_d;
      snap_q      <= snap_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      pressed_q   <= |deb_d;
      evt_q       <= evt_d;
      evt_idx_q   <= evt_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Disabling the scanner releases every row immediately.
  assign row_pins_o  = en_i ? row_pins_q : 4'b1111;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign pressed_o   = pressed_q;
  assign overflow_o  = overflow_q;

endmodule
